// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with sub-word load extraction and write-back mux.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_RegWrite,
  input  logic [4:0]  mem_WriteAddr,
  input  logic [1:0]  mem_MemtoReg,
  input  logic [2:0]  mem_LoadType,
  input  logic [31:0] mem_ALUOut,
  input  logic [31:0] mem_ReadData,
  input  logic [31:0] mem_PCplus4,
  output logic        RegWrite,
  output logic [4:0]  RF_WriteAddr,
  output logic [31:0] RF_WriteData,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic        wb_valid,
  output logic [31:0] retire_count
`else
  output logic        wb_valid
`endif
);

  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  logic        r_we;
  logic        r_valid;
  logic [4:0]  r_addr;
  logic [31:0] r_data;

  logic [1:0]  w_byte_sel;
  logic        w_half_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_hold;

  // big-endian numbers lanes from the MSB end
  assign w_byte_sel = (BIG_ENDIAN != 0) ? ~mem_ALUOut[1:0]
                                        : mem_ALUOut[1:0];
  assign w_half_sel = (BIG_ENDIAN != 0) ? ~mem_ALUOut[1]
                                        : mem_ALUOut[1];

  always_comb begin
    w_byte = 8'h00;
    unique case (w_byte_sel)
      2'd0: w_byte = mem_ReadData[7:0];
      2'd1: w_byte = mem_ReadData[15:8];
      2'd2: w_byte = mem_ReadData[23:16];
      2'd3: w_byte = mem_ReadData[31:24];
    endcase
  end

  assign w_half = w_half_sel ? mem_ReadData[31:16]
                             : mem_ReadData[15:0];

  always_comb begin
    w_load = mem_ReadData;
    case (mem_LoadType)
      LT_LH:   w_load = {{16{w_half[15]}}, w_half};
      LT_LHU:  w_load = {16'h0000, w_half};
      LT_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  w_load = {24'h000000, w_byte};
      default: w_load = mem_ReadData;
    endcase
  end

  always_comb begin
    w_wdata = mem_ALUOut;
    case (mem_MemtoReg)
      WB_LOAD: w_wdata = w_load;
      WB_LINK: w_wdata = mem_PCplus4;
      default: w_wdata = mem_ALUOut;
    endcase
  end

  assign w_we   = mem_RegWrite & (mem_WriteAddr != 5'd0);
  assign w_hold = stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'h0;
    end else if (w_hold) begin
      r_we    <= r_we;
      r_valid <= r_valid;
      r_addr  <= r_addr;
      r_data  <= r_data;
    end else if (flush || !mem_valid) begin
      r_we    <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= 5'd0;
      r_data  <= 32'h0;
    end else begin
      r_we    <= w_we;
      r_valid <= 1'b1;
      r_addr  <= mem_WriteAddr;
      r_data  <= w_wdata;
    end
  end

  assign RegWrite     = r_we;
  assign wb_valid     = r_valid;
  assign RF_WriteAddr = r_addr;
  assign RF_WriteData = r_data;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // counts the instruction leaving WB on this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_cnt <= 32'h0;
    end else if (r_valid && !w_hold) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_count = r_retire_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage, little- and big-endian instances
// checked against a behavioural model of the write-back rules.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mv;
  logic        mrw;
  logic [4:0]  mwa;
  logic [1:0]  mmtr;
  logic [2:0]  mlt;
  logic [31:0] alu;
  logic [31:0] rdw;
  logic [31:0] pc4;

  logic        le_we, be_we;
  logic        le_vl, be_vl;
  logic [4:0]  le_wa, be_wa;
  logic [31:0] le_wd, be_wd;
  logic [31:0] le_cnt, be_cnt;

  logic        e_we;
  logic        e_vl;
  logic [4:0]  e_wa;
  logic [31:0] e_wd_le;
  logic [31:0] e_wd_be;
  logic [31:0] e_cnt;

  int n_chk;
  int n_pass;

  mem_wb_stage #(.BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mv), .mem_RegWrite(mrw), .mem_WriteAddr(mwa),
    .mem_MemtoReg(mmtr), .mem_LoadType(mlt), .mem_ALUOut(alu),
    .mem_ReadData(rdw), .mem_PCplus4(pc4),
    .RegWrite(le_we), .RF_WriteAddr(le_wa), .RF_WriteData(le_wd),
`ifdef MEM_WB_RETIRE_CNT_EN
    .wb_valid(le_vl), .retire_count(le_cnt)
`else
    .wb_valid(le_vl)
`endif
  );

  mem_wb_stage #(.BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mv), .mem_RegWrite(mrw), .mem_WriteAddr(mwa),
    .mem_MemtoReg(mmtr), .mem_LoadType(mlt), .mem_ALUOut(alu),
    .mem_ReadData(rdw), .mem_PCplus4(pc4),
    .RegWrite(be_we), .RF_WriteAddr(be_wa), .RF_WriteData(be_wd),
`ifdef MEM_WB_RETIRE_CNT_EN
    .wb_valid(be_vl), .retire_count(be_cnt)
`else
    .wb_valid(be_vl)
`endif
  );

`ifndef MEM_WB_RETIRE_CNT_EN
  assign le_cnt = 32'h0;
  assign be_cnt = 32'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ld_val(input int be,
      input logic [2:0] lt, input logic [31:0] a, input logic [31:0] w);
    int off;
    int sh;
    logic [31:0] v;
    v = w;
    if (lt == 3'd1 || lt == 3'd2) begin
      off = int'(a[1]);
      sh = (be != 0) ? 16 * (1 - off) : 16 * off;
      v = (w >> sh) & 32'h0000_FFFF;
      if (lt == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else if (lt == 3'd3 || lt == 3'd4) begin
      off = int'(a[1:0]);
      sh = (be != 0) ? 8 * (3 - off) : 8 * off;
      v = (w >> sh) & 32'h0000_00FF;
      if (lt == 3'd3 && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] wb_val(input int be);
    if (mmtr == 2'd1) return ld_val(be, mlt, alu, rdw);
    if (mmtr == 2'd2) return pc4;
    return alu;
  endfunction

  task automatic model_zero();
    e_we = 1'b0;
    e_vl = 1'b0;
    e_wa = 5'd0;
    e_wd_le = 32'h0;
    e_wd_be = 32'h0;
  endtask

  task automatic check_all();
    chk("le_we", {31'b0, le_we}, {31'b0, e_we});
    chk("le_valid", {31'b0, le_vl}, {31'b0, e_vl});
    chk("le_addr", {27'b0, le_wa}, {27'b0, e_wa});
    chk("le_data", le_wd, e_wd_le);
    chk("be_we", {31'b0, be_we}, {31'b0, e_we});
    chk("be_valid", {31'b0, be_vl}, {31'b0, e_vl});
    chk("be_addr", {27'b0, be_wa}, {27'b0, e_wa});
    chk("be_data", be_wd, e_wd_be);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("le_cnt", le_cnt, e_cnt);
    chk("be_cnt", be_cnt, e_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (!(stall && !flush)) begin
        if (e_vl) e_cnt = e_cnt + 32'd1;
        if (flush || !mv) begin
          model_zero();
        end else begin
          e_vl = 1'b1;
          e_we = mrw && (mwa != 5'd0);
          e_wa = mwa;
          e_wd_le = wb_val(0);
          e_wd_be = wb_val(1);
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] wa,
      input logic [1:0] mt, input logic [2:0] lt, input logic [31:0] a,
      input logic [31:0] d, input logic [31:0] p);
    mv = v; mrw = rw; mwa = wa; mmtr = mt;
    mlt = lt; alu = a; rdw = d; pc4 = p;
  endtask

  task automatic drive_rand();
    drive(($urandom_range(0, 7) != 0), 1'($urandom),
          5'($urandom), 2'($urandom), 3'($urandom),
          $urandom, $urandom, $urandom);
    stall = ($urandom_range(0, 5) == 0);
    flush = ($urandom_range(0, 9) == 0);
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic reset_pulse();
    #3;
    reset = 1'b0;
    #1;
    model_zero();
    e_cnt = 32'h0;
    chk("rst_async_we", {31'b0, le_we}, 32'h0);
    chk("rst_async_data", le_wd, 32'h0);
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    model_zero();
    e_cnt = 32'h0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // lb sign extension
    drive(1'b1, 1'b1, 5'd7, 2'd1, 3'd3, 32'h1003, 32'h80FF_1234, 32'h0);
    tick();
    chk("lb_sext", le_wd, 32'hFFFF_FF80);
    chk("lb_we", {31'b0, le_we}, 32'h1);

    // lhu zero extension, both endians
    drive(1'b1, 1'b1, 5'd8, 2'd1, 3'd2, 32'h2002, 32'hBEEF_0001, 32'h0);
    tick();
    chk("lhu_le", le_wd, 32'h0000_BEEF);
    chk("lhu_be", be_wd, 32'h0000_0001);

    // link write and r0 suppression
    drive(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0040_0010);
    tick();
    chk("jal_we", {31'b0, le_we}, 32'h1);
    chk("jal_data", le_wd, 32'h0040_0010);
    mwa = 5'd0;
    tick();
    chk("r0_we", {31'b0, le_we}, 32'h0);
    chk("r0_valid", {31'b0, le_vl}, 32'h1);

    // stall holds, flush beats stall
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, $urandom, 32'h0, 32'h0);
      tick();
      chk("stall_hold", le_wd, 32'h1234);
    end
    flush = 1'b1;
    tick();
    chk("flush_we", {31'b0, le_we}, 32'h0);
    chk("flush_valid", {31'b0, le_vl}, 32'h0);
    stall = 1'b0;
    flush = 1'b0;

    // async reset with a write pending
    drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'hCAFE_0003, 32'h0, 32'h0);
    tick();
    chk("pre_rst_we", {31'b0, le_we}, 32'h1);
    reset_pulse();
    tick();
    chk("post_rst_cap", le_wd, 32'hCAFE_0003);

`ifdef MEM_WB_RETIRE_CNT_EN
    // counter wrap
    drive(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    force dut_le.r_retire_cnt = 32'hFFFF_FFFE;
    force dut_be.r_retire_cnt = 32'hFFFF_FFFE;
    #1;
    release dut_le.r_retire_cnt;
    release dut_be.r_retire_cnt;
    e_cnt = 32'hFFFF_FFFE;
    tick();
    tick();
    chk("cnt_wrap", le_cnt, 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      drive_rand();
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse();
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
